// File: rtl/mdu_pkg.sv
// mdu_pkg: md_op encodings, FSM state type, default latencies and the
// 32x32 multiply / divide helpers shared by the MDU.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'h0;
  localparam logic [3:0] MD_MULT  = 4'h1;
  localparam logic [3:0] MD_MULTU = 4'h2;
  localparam logic [3:0] MD_DIV   = 4'h3;
  localparam logic [3:0] MD_DIVU  = 4'h4;
  localparam logic [3:0] MD_MTHI  = 4'h5;
  localparam logic [3:0] MD_MTLO  = 4'h6;
  localparam logic [3:0] MD_MADD  = 4'h7;
  localparam logic [3:0] MD_MADDU = 4'h8;
  localparam logic [3:0] MD_MSUB  = 4'h9;
  localparam logic [3:0] MD_MSUBU = 4'hA;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_e;

  // Full 64-bit product; sgn selects two's-complement operands.
  function automatic logic [63:0] md_mul(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic        sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed mode divides magnitudes and fixes
  // signs afterwards, which also yields 0x80000000 / 0 for the overflow case.
  function automatic logic [63:0] md_div(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic        sgn);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    ua = (sgn && a[31]) ? -a : a;
    ub = (sgn && b[31]) ? -b : b;
    q  = '0;
    r  = '0;
    if (ub != '0) begin
      q = ua / ub;
      r = ua % ub;
    end
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31])           r = -r;
    return {r, q};
  endfunction

endpackage

// File: rtl/mdu.sv
// mdu: HI/LO multiply/divide unit answering the EX-stage start/busy handshake.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate operations.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  mdu_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   pend_hi_q;
  logic [31:0]   pend_lo_q;
  logic          pend_wr_q;

  logic          launch_d;
  logic [CW-1:0] cnt_d;
  logic [63:0]   pend_d;
  logic          pend_wr_d;
  logic          wr_hi_d;
  logic          wr_lo_d;

  // Result is formed at acceptance from the live operands and held in the
  // pending registers; HI/LO themselves only change on the completion edge.
  always_comb begin
    launch_d  = 1'b0;
    cnt_d     = '0;
    pend_d    = '0;
    pend_wr_d = 1'b0;
    wr_hi_d   = 1'b0;
    wr_lo_d   = 1'b0;
    case (md_op)
      MD_MULT: begin
        launch_d  = 1'b1;
        cnt_d     = MULT_LOAD;
        pend_wr_d = 1'b1;
        pend_d    = md_mul(rs_val, rt_val, 1'b1);
      end
      MD_MULTU: begin
        launch_d  = 1'b1;
        cnt_d     = MULT_LOAD;
        pend_wr_d = 1'b1;
        pend_d    = md_mul(rs_val, rt_val, 1'b0);
      end
      MD_DIV: begin
        launch_d  = 1'b1;
        cnt_d     = DIV_LOAD;
        pend_wr_d = (rt_val != '0);
        pend_d    = md_div(rs_val, rt_val, 1'b1);
      end
      MD_DIVU: begin
        launch_d  = 1'b1;
        cnt_d     = DIV_LOAD;
        pend_wr_d = (rt_val != '0);
        pend_d    = md_div(rs_val, rt_val, 1'b0);
      end
      MD_MTHI: wr_hi_d = 1'b1;
      MD_MTLO: wr_lo_d = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD: begin
        launch_d  = 1'b1;
        cnt_d     = MULT_LOAD;
        pend_wr_d = 1'b1;
        pend_d    = {hi_q, lo_q} + md_mul(rs_val, rt_val, 1'b1);
      end
      MD_MADDU: begin
        launch_d  = 1'b1;
        cnt_d     = MULT_LOAD;
        pend_wr_d = 1'b1;
        pend_d    = {hi_q, lo_q} + md_mul(rs_val, rt_val, 1'b0);
      end
      MD_MSUB: begin
        launch_d  = 1'b1;
        cnt_d     = MULT_LOAD;
        pend_wr_d = 1'b1;
        pend_d    = {hi_q, lo_q} - md_mul(rs_val, rt_val, 1'b1);
      end
      MD_MSUBU: begin
        launch_d  = 1'b1;
        cnt_d     = MULT_LOAD;
        pend_wr_d = 1'b1;
        pend_d    = {hi_q, lo_q} - md_mul(rs_val, rt_val, 1'b0);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (wr_hi_d) hi_q <= rs_val;
            if (wr_lo_d) lo_q <= rs_val;
            if (launch_d) begin
              state_q   <= ST_RUN;
              busy_q    <= 1'b1;
              cnt_q     <= cnt_d;
              pend_hi_q <= pend_d[63:32];
              pend_lo_q <= pend_d[31:0];
              pend_wr_q <= pend_wr_d;
            end
          end
        end
        ST_RUN: begin
          // Counter reaching 0 on this edge is the completion edge.
          if (cnt_q == CW'(1)) begin
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            pend_wr_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu; expected HI/LO and busy length are queued
// at issue and compared when the unit goes idle.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference model built on 64-bit integer arithmetic.
  function automatic void model_op(input logic [3:0] op, input logic [31:0] rs,
                                   input logic [31:0] rt, output int cyc);
    longint          a, b, q, r;
    logic [63:0]     up;
    cyc = 0;
    case (op)
      MD_MULT: begin
        q = longint'($signed(rs)) * longint'($signed(rt));
        model_hi = q[63:32];
        model_lo = q[31:0];
        cyc = MC;
      end
      MD_MULTU: begin
        up = {32'h0, rs} * {32'h0, rt};
        model_hi = up[63:32];
        model_lo = up[31:0];
        cyc = MC;
      end
      MD_DIV: begin
        if (rt != 0) begin
          a = longint'($signed(rs));
          b = longint'($signed(rt));
          q = a / b;
          r = a % b;
          model_lo = q[31:0];
          model_hi = r[31:0];
        end
        cyc = DC;
      end
      MD_DIVU: begin
        if (rt != 0) begin
          model_lo = rs / rt;
          model_hi = rs % rt;
        end
        cyc = DC;
      end
      MD_MTHI: model_hi = rs;
      MD_MTLO: model_lo = rs;
      default: ;
    endcase
  endfunction

  function automatic void push_model(input logic [3:0] op, input logic [31:0] rs,
                                     input logic [31:0] rt);
    exp_t e;
    int   c;
    model_op(op, rs, rt, c);
    e.hi = model_hi;
    e.lo = model_lo;
    e.cycles = c;
    sb_q.push_back(e);
  endfunction

  function automatic void push_lit(input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.cycles = c;
    sb_q.push_back(e);
    model_hi = h;
    model_lo = l;
  endfunction

  // Called just after an edge; counts busy negedges and watches HI/LO hold.
  task automatic wait_done(output int n, output bit held);
    logic [31:0] h0, l0;
    h0 = hi;
    l0 = lo;
    n = 0;
    held = 1'b1;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(negedge clk);
    end
  endtask

  // Entered at a negedge; leaves at the negedge where busy is low again.
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int n, output bit held);
    md_op  = op;
    rs_val = rs;
    rt_val = rt;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = MD_NONE;
    wait_done(n, held);
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    start  = 1'b0;
    md_op  = MD_NONE;
    rs_val = '0;
    rt_val = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo;
    bit saw_busy;
    saw_busy = 1'b0;
    md_op = MD_MTHI; rs_val = 32'h12345678; rt_val = '0; start = 1'b1;
    @(posedge clk); #1;
    md_op = MD_MTLO; rs_val = 32'h9ABCDEF0;
    @(negedge clk);
    if (busy !== 1'b0) saw_busy = 1'b1;
    checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    @(negedge clk);
    if (busy !== 1'b0) saw_busy = 1'b1;
    checks++; if (lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", lo); end
    checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", hi); end
    checks++; if (saw_busy !== 1'b0) begin failures++; $display("FAIL mtx_busy got=%b exp=0", saw_busy); end
    model_hi = 32'h12345678;
    model_lo = 32'h9ABCDEF0;
  endtask

  task automatic test_mult;
    int n; bit held; exp_t e;
    logic [3:0] op; logic [31:0] a, b;
    push_lit(32'hFFFFFFFF, 32'hFFFFFFEB, MC);
    run_op(MD_MULT, 32'hFFFFFFFD, 32'd7, n, held);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL mult_plan got=%h%h exp=%h%h", hi, lo, e.hi, e.lo); end
    checks++; if (n !== e.cycles) begin failures++; $display("FAIL mult_plan_busy got=%0d exp=%0d", n, e.cycles); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL mult_plan_hold got=%b exp=1", held); end
    for (int i = 0; i < 6; i++) begin
      op = (i % 2 == 0) ? MD_MULT : MD_MULTU;
      a = $urandom;
      b = $urandom;
      push_model(op, a, b);
      run_op(op, a, b, n, held);
      e = sb_q.pop_front();
      checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL mult_rand op=%0d a=%h b=%h got=%h%h exp=%h%h", op, a, b, hi, lo, e.hi, e.lo); end
      checks++; if (n !== e.cycles) begin failures++; $display("FAIL mult_rand_busy got=%0d exp=%0d", n, e.cycles); end
    end
  endtask

  task automatic test_div;
    int n; bit held; exp_t e;
    logic [3:0] op; logic [31:0] a, b;
    push_lit(32'h00000001, 32'hFFFFFFFD, DC);
    run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, n, held);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL div_plan got=%h%h exp=%h%h", hi, lo, e.hi, e.lo); end
    checks++; if (n !== e.cycles) begin failures++; $display("FAIL div_plan_busy got=%0d exp=%0d", n, e.cycles); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL div_plan_hold got=%b exp=1", held); end
    push_lit(32'h00000007, 32'h00000000, DC);
    run_op(MD_DIVU, 32'd7, 32'hFFFFFFFE, n, held);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL divu_plan got=%h%h exp=%h%h", hi, lo, e.hi, e.lo); end
    push_lit(32'h00000000, 32'h80000000, DC);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, n, held);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL div_overflow got=%h%h exp=%h%h", hi, lo, e.hi, e.lo); end
    for (int i = 0; i < 6; i++) begin
      op = (i % 2 == 0) ? MD_DIV : MD_DIVU;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 30);
      push_model(op, a, b);
      run_op(op, a, b, n, held);
      e = sb_q.pop_front();
      checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL div_rand op=%0d a=%h b=%h got=%h%h exp=%h%h", op, a, b, hi, lo, e.hi, e.lo); end
      checks++; if (n !== e.cycles) begin failures++; $display("FAIL div_rand_busy got=%0d exp=%0d", n, e.cycles); end
    end
  endtask

  task automatic test_divzero;
    int n; bit held; exp_t e;
    run_op(MD_MTHI, 32'h11, '0, n, held);
    run_op(MD_MTLO, 32'h22, '0, n, held);
    push_lit(32'h11, 32'h22, DC);
    run_op(MD_DIVU, 32'd5, 32'd0, n, held);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL divzero_keep got=%h%h exp=%h%h", hi, lo, e.hi, e.lo); end
    checks++; if (n !== e.cycles) begin failures++; $display("FAIL divzero_busy got=%0d exp=%0d", n, e.cycles); end
  endtask

  task automatic test_ignore_start;
    int n; bit held; exp_t e;
    int pre;
    pre = 0;
    push_model(MD_MULTU, 32'h0001_0000, 32'h0003_0003);
    md_op = MD_MULTU; rs_val = 32'h0001_0000; rt_val = 32'h0003_0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    repeat (2) begin
      @(negedge clk);
      if (busy === 1'b1) pre++;
    end
    md_op = MD_MTLO; rs_val = 32'hDEADBEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    wait_done(n, held);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL ignore_result got=%h%h exp=%h%h", hi, lo, e.hi, e.lo); end
    checks++; if (pre + n !== e.cycles) begin failures++; $display("FAIL ignore_busy got=%0d exp=%0d", pre + n, e.cycles); end
  endtask

  task automatic test_back_to_back;
    int n1, n2; bit h1, h2; exp_t e;
    push_model(MD_MULT, 32'h7FFFFFFF, 32'h80000000);
    push_model(MD_DIV, 32'hFFFFFF9C, 32'd7);
    run_op(MD_MULT, 32'h7FFFFFFF, 32'h80000000, n1, h1);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL b2b_first got=%h%h exp=%h%h", hi, lo, e.hi, e.lo); end
    run_op(MD_DIV, 32'hFFFFFF9C, 32'd7, n2, h2);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL b2b_second got=%h%h exp=%h%h", hi, lo, e.hi, e.lo); end
    checks++; if (n2 !== e.cycles) begin failures++; $display("FAIL b2b_second_busy got=%0d exp=%0d", n2, e.cycles); end
  endtask

  task automatic test_reset_abort;
    bit disturbed; int n; bit held; exp_t e;
    disturbed = 1'b0;
    md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL abort_hilo got=%h%h exp=0", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    repeat (DC + 3) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) disturbed = 1'b1;
    end
    checks++; if (disturbed !== 1'b0) begin failures++; $display("FAIL abort_late_commit got=%b exp=0", disturbed); end
    model_hi = '0;
    model_lo = '0;
    push_model(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n, held);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL post_abort got=%h%h exp=%h%h", hi, lo, e.hi, e.lo); end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_divzero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the P6 five-stage MIPS pipeline. It executes `MULT`, `MULTU`, `DIV`, `DIVU`, `MTHI` and `MTLO` on the HI/LO register pair. It sits beside the EX-stage ALU as the responder to the pipeline's start/busy handshake. The hazard unit stalls any MD-class instruction in D while `start | busy` is high.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `MULT`/`MULTU`.
- `DIV_CYCLES`, default 10: busy cycles for `DIV`/`DIVU`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low; 0 clears all state immediately.
- `start`, input, 1: EX-stage request qualifier, sampled on the rising edge.
- `md_op`, input, 4: operation code, encodings defined in `mdu_pkg`.
- `rs_val`, input, 32: forwarded rs operand.
- `rt_val`, input, 32: forwarded rt operand.
- `busy`, output, 1: registered; an operation is in flight.
- `hi`, output, 32: architectural HI.
- `lo`, output, 32: architectural LO.

## Operation

- **Reset**: while `reset`=0, `hi`=0, `lo`=0, `busy`=0, the counter is 0 and pending results are cleared. Asserting reset mid-operation aborts the operation; nothing is committed.
- **Acceptance**: a request is accepted on an edge where `start`=1 and `busy`=0. A request with `start`=1 while `busy`=1 is ignored with no side effects; the pipeline never issues one.
- **`MTHI`/`MTLO`**: `hi`/`lo` takes `rs_val` on the accepting edge. `busy` stays 0.
- **`MULT`**: signed 32×32 multiply to a 64-bit result; `{hi,lo}` = product.
- **`MULTU`**: same as `MULT`, unsigned.
- **`DIV`**: signed divide; `lo` = quotient truncated toward zero, `hi` = remainder carrying the dividend's sign.
- **`DIVU`**: unsigned divide with the same `lo`/`hi` roles.
- **Result computation**: results are computed from the operands latched on the accepting edge into pending registers. They commit to `hi`/`lo` only on the completion edge.
- **Divide by zero** (`rt_val`=0 on `DIV`/`DIVU`): `busy` runs the full `DIV_CYCLES`, then `hi`/`lo` are left unchanged.
- **Signed overflow** (`0x80000000 / 0xFFFFFFFF`): `lo`=`0x80000000`, `hi`=0.
- **Unknown `md_op`**: ignored; no busy, no write.

States:
- **IDLE** → **RUN** on acceptance of a multiply or divide; the counter is loaded with `MULT_CYCLES` or `DIV_CYCLES`.
- **RUN**: the counter decrements each edge. When it reaches 0: commit, then → **IDLE**.

## Timing

- Accepting edge T for a multiply: `busy`=1 from after edge T through edge T+`MULT_CYCLES`. `hi`/`lo` are updated and `busy` falls on that same edge, T+`MULT_CYCLES`.
- Divide follows the same timing with `DIV_CYCLES`.
- `hi`/`lo` are registered outputs. MFHI/MFLO issued after `busy` falls sees the new value with zero added latency.
- Back-to-back: a new request is accepted on the edge right after `busy` falls. There are no idle gap cycles.
- During RUN, `hi`/`lo` hold their pre-operation values.

## Configuration

- **`MDU_MADD_EN` defined**: adds `MADD`, `MADDU`, `MSUB`, `MSUBU`.
  - The operation is `{hi,lo} ± product`, with the 64-bit accumulation wrapping modulo 2^64.
  - Latency is `MULT_CYCLES`.
  - The accumulation uses `{hi,lo}` as sampled at the accepting edge.
- **`MDU_MADD_EN` undefined**: those four encodings are treated as unknown ops and ignored.

## Structure

- `mdu_pkg` holds:
  - the `md_op` encoding constants: `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`, plus `MD_MADD`, `MD_MADDU`, `MD_MSUB`, `MD_MSUBU`;
  - the state typedef;
  - the default latency constants.
- Single module, no sub-module.

## Test plan

- `MULT`, rs=`0xFFFFFFFD` (−3), rt=7 → `busy` high exactly 5 cycles; then `hi`=`0xFFFFFFFF`, `lo`=`0xFFFFFFEB`.
- `DIV`, rs=7, rt=`0xFFFFFFFE` (−2) → after 10 cycles `lo`=`0xFFFFFFFD`, `hi`=1. `DIVU` with the same operands → `lo`=0, `hi`=7.
- `MTHI` rs=`0x12345678`, then `MTLO` rs=`0x9ABCDEF0` on consecutive edges → both visible the next cycle; `busy` never asserts.
- `DIVU` with rt=0 from `hi`=`0x11`, `lo`=`0x22` → `busy` runs 10 cycles; `hi`/`lo` stay `0x11`/`0x22`.
- `MULTU` started, `start`=1 with `MTLO` pulsed at cycle 2 → ignored; `lo` ends as the product low word.
- `reset`=0 pulsed at cycle 3 of a `DIV` → `busy`, `hi` and `lo` all 0 immediately; no later commit.
